// File: rtl/seq_mult_32.sv
`default_nettype none
// ============================================================================
//  Module   : seq_mult_32
//  Purpose  : 32x32 -> 64 bit sequential shift-add multiplier with a fixed
//             32-cycle latency. One iteration per BUSY cycle. The product
//             registers P_hi:P_lo only change on the final iteration edge,
//             so a downstream result mux never sees partial sums.
//  Config   : SEQ_MULT_SIGNED_EN - when defined, A and B are two's
//             complement. Magnitudes are multiplied and the 64-bit result is
//             negated on the final edge if the operand signs differ. When
//             undefined, A and B are unsigned and no sign logic is built.
//  Ports    : clk    - clock, all state changes on its rising edge
//             rst_n  - synchronous active-low reset
//             start  - begin a multiply with the current A and B
//             A, B   - multiplicand / multiplier (32 bits each)
//             busy   - multiply in progress
//             done   - P_lo / P_hi hold a valid result
//             P_lo   - product bits [31:0]
//             P_hi   - product bits [63:32]
//  Revision : 1.0 - initial release
// ============================================================================
module seq_mult_32 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] P_lo,
    output logic [31:0] P_hi
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] mcand;      // captured multiplicand (magnitude in signed build)
    logic [31:0] mplier;     // captured multiplier, shifted right each iteration
    logic [63:0] acc;        // running partial product
    logic [4:0]  count;      // iteration index 0..31
    logic        last_iter;
    logic [32:0] sum;        // upper half plus addend, carry kept
    logic [63:0] acc_next;
    logic [63:0] result;
    logic [31:0] a_in;
    logic [31:0] b_in;

`ifdef SEQ_MULT_SIGNED_EN
    logic        neg;        // operand signs differed at capture

    assign a_in   = A[31] ? (~A + 32'd1) : A;
    assign b_in   = B[31] ? (~B + 32'd1) : B;
    // Sign correction is applied to the value being loaded on the last
    // iteration edge, which keeps the latency at exactly 32 cycles.
    assign result = neg ? (~acc_next + 64'd1) : acc_next;
`else
    assign a_in   = A;
    assign b_in   = B;
    assign result = acc_next;
`endif

    assign last_iter = (count == 5'd31);

    // One shift-add step: conditionally add the multiplicand into the upper
    // half, then shift the whole accumulator right with the carry entering
    // at the top.
    always_comb begin
        sum      = {1'b0, acc[63:32]} + {1'b0, (mplier[0] ? mcand : 32'd0)};
        acc_next = {sum, acc[31:1]};
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)     state_next = BUSY;
            BUSY:    if (last_iter) state_next = DONE;
            DONE:    if (start)     state_next = BUSY;
            default:                state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs. Reset has priority over start, so
    // a start coinciding with reset is dropped.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            P_lo   <= 32'd0;
            P_hi   <= 32'd0;
            mcand  <= 32'd0;
            mplier <= 32'd0;
            acc    <= 64'd0;
            count  <= 5'd0;
`ifdef SEQ_MULT_SIGNED_EN
            neg    <= 1'b0;
`endif
        end else begin
            busy <= (state_next == BUSY);
            done <= (state_next == DONE);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand  <= a_in;
                        mplier <= b_in;
                        acc    <= 64'd0;
                        count  <= 5'd0;
`ifdef SEQ_MULT_SIGNED_EN
                        neg    <= A[31] ^ B[31];
`endif
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    count  <= count + 5'd1;
                    if (last_iter) begin
                        {P_hi, P_lo} <= result;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_mult_32.md
SEQ_MULT_32 -- requirements
Module: seq_mult_32

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port start, input, 1 bit: request to begin a multiply with the current A and B.
REQ-004 SHALL have port A, input, 32 bits: multiplicand.
REQ-005 SHALL have port B, input, 32 bits: multiplier.
REQ-006 SHALL have port busy, output, 1 bit: multiply in progress.
REQ-007 SHALL have port done, output, 1 bit: P_lo and P_hi hold a valid result.
REQ-008 SHALL have port P_lo, output, 32 bits: product bits [31:0], feeding the 32-bit result-select 2:1 mux downstream.
REQ-009 SHALL have port P_hi, output, 32 bits: product bits [63:32].

Function
REQ-010 SHALL implement the FSM states IDLE, BUSY and DONE, with all outputs registered.
REQ-011 SHALL sample start in IDLE or DONE at edge k, then capture A and B, clear the iteration counter and the accumulator, clear done, and enter BUSY.
REQ-012 SHALL perform exactly one shift-add iteration per BUSY cycle: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half (33-bit sum, carry kept); then shift the 64-bit accumulator right by one.
REQ-013 SHALL use a fixed latency: busy=1 in cycles k+1..k+32, and at edge k+32 go to DONE with done=1, busy=0 and P_hi:P_lo loaded.
REQ-014 SHALL keep latency independent of operand values (zero operands still take 32 cycles).
REQ-015 SHALL ignore start while BUSY: no restart, and operands already captured are unaffected.
REQ-016 SHALL hold done, P_lo and P_hi stable in DONE until the next accepted start or reset.
REQ-017 SHALL go from DONE to BUSY on start with no idle cycle between (back-to-back operation).
REQ-018 SHALL keep P_lo and P_hi unchanged while BUSY, so the downstream mux never sees partial sums.
REQ-019 SHALL never assert busy and done together.
REQ-020 SHALL not depend on changes to A or B after the start edge.

Reset
REQ-021 SHALL, when rst_n=0 at a rising edge, force IDLE with busy=0, done=0, P_lo=0, P_hi=0, and clear the counter and accumulator.
REQ-022 SHALL let reset during BUSY abort the operation with no result, and SHALL ignore start in that same cycle.
REQ-023 SHALL accept start on the first edge after rst_n returns to 1.

Configuration
REQ-024 SHALL recognise the macro SEQ_MULT_SIGNED_EN.
REQ-025 SHALL, with SEQ_MULT_SIGNED_EN defined, treat A and B as two's complement: multiply magnitudes, then negate the 64-bit result if the signs differ, with the same 32-cycle latency (the correction is folded into the final iteration edge).
REQ-026 SHALL, with SEQ_MULT_SIGNED_EN undefined, treat A and B as unsigned and contain no sign logic.

Verification
REQ-027 SHALL pass this check: reset, then A=3, B=5, start for 1 cycle -> busy for 32 cycles, then done=1, P_hi=0, P_lo=15.
REQ-028 SHALL pass this check (unsigned build): A=B=0xFFFFFFFF -> P_hi=0xFFFFFFFE, P_lo=0x00000001.
REQ-029 SHALL pass this check (signed build): A=0xFFFFFFFE (-2), B=3 -> P_hi=0xFFFFFFFF, P_lo=0xFFFFFFFA; and A=B=0xFFFFFFFF -> P_hi=0, P_lo=1.
REQ-030 SHALL pass this check: start pulsed again at cycle k+10 with A=7 -> ignored, and the first result is delivered at k+32 unchanged.
REQ-031 SHALL pass this check: rst_n=0 at cycle k+16 -> next cycle IDLE with busy=0, done=0, P=0; then a new start (A=2, B=2) -> P_lo=4.
REQ-032 SHALL pass this check: start held high through DONE -> a second multiply begins immediately, P holds the first result until the second completes 32 cycles later.
